// File: rtl/maze_round_ctrl.sv
// maze_round_ctrl
// ---------------
// Round sequencer for the maze. It starts a game, reloads the pellet map
// at the start of each level, gates movement, accumulates score, tracks
// lives and level, and runs the level-clear flash.
//
// Ports:
//   clock       in   1  system clock, rising edge
//   Reset       in   1  synchronous, active-high
//   frame_tick  in   1  one-cycle pulse per video frame
//   start       in   1  start button level (edge-detected inside)
//   eat         in   1  one-cycle pulse per pellet cleared
//   finish      in   1  no pellets remain
//   pac_dead    in   1  Pacman/ghost collision
//   map_reload  out  1  one-cycle pulse, ORed into the pellet store reset
//   play_en     out  1  movement enable
//   flash       out  1  maze flash colour select
//   score       out 16  binary score, saturating
//   lives       out  2  remaining lives
//   level       out  4  current level, starts at 1
//   state       out  3  FSM state for HUD/debug
//     (IDLE=0 RELOAD=1 READY=2 PLAY=3 DYING=4 CLEAR=5 GAMEOVER=6)
//
// All outputs come straight from registers.
module maze_round_ctrl #(
  parameter int unsigned START_LIVES   = 3,
  parameter int unsigned PELLET_POINTS = 10,
  parameter int unsigned READY_FRAMES  = 60,
  parameter int unsigned DEATH_FRAMES  = 90,
  parameter int unsigned CLEAR_FRAMES  = 120,
  parameter int unsigned FLASH_PERIOD  = 15,
  parameter int unsigned MAX_LEVEL     = 15
) (
  input  logic        clock,
  input  logic        Reset,
  input  logic        frame_tick,
  input  logic        start,
  input  logic        eat,
  input  logic        finish,
  input  logic        pac_dead,
  output logic        map_reload,
  output logic        play_en,
  output logic        flash,
  output logic [15:0] score,
  output logic [1:0]  lives,
  output logic [3:0]  level,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RELOAD   = 3'd1,
    S_READY    = 3'd2,
    S_PLAY     = 3'd3,
    S_DYING    = 3'd4,
    S_CLEAR    = 3'd5,
    S_GAMEOVER = 3'd6
  } state_t;

  // Counters compare against "last tick" values so a full period of N ticks
  // ends on the N-th tick.
  localparam logic [7:0] READY_LAST = 8'(READY_FRAMES - 1);
  localparam logic [7:0] DEATH_LAST = 8'(DEATH_FRAMES - 1);
  localparam logic [7:0] CLEAR_LAST = 8'(CLEAR_FRAMES - 1);
  localparam logic [7:0] FLASH_LAST = 8'(FLASH_PERIOD - 1);
  localparam logic [1:0] LIVES_INIT = 2'(START_LIVES);
  localparam logic [3:0] LEVEL_MAX  = 4'(MAX_LEVEL);

  state_t      state_q, state_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic [7:0]  flash_cnt_q, flash_cnt_d;
  logic        flash_q, flash_d;
  logic [15:0] score_q, score_d;
  logic [1:0]  lives_q, lives_d;
  logic [3:0]  level_q, level_d;
  logic        map_reload_q, play_en_q;
  logic        start_q;
  logic        start_rise;
  logic [16:0] score_sum;
  logic [15:0] score_sat;

  assign start_rise = start & ~start_q;

  // 17-bit sum so the carry shows overflow; clamp at all-ones.
  assign score_sum = {1'b0, score_q} + 17'(PELLET_POINTS);
  assign score_sat = score_sum[16] ? 16'hFFFF : score_sum[15:0];

  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    flash_cnt_d = flash_cnt_q;
    flash_d     = flash_q;
    score_d     = score_q;
    lives_d     = lives_q;
    level_d     = level_q;

    case (state_q)
      S_IDLE, S_GAMEOVER: begin
        if (start_rise) begin
          score_d = 16'd0;
          lives_d = LIVES_INIT;
          level_d = 4'd1;
          state_d = S_RELOAD;
        end
      end

      S_RELOAD: begin
        frame_cnt_d = 8'd0;
        state_d     = S_READY;
      end

      S_READY: begin
        if (frame_tick) begin
          if (frame_cnt_q == READY_LAST) begin
            frame_cnt_d = 8'd0;
            state_d     = S_PLAY;
          end else begin
            frame_cnt_d = frame_cnt_q + 8'd1;
          end
        end
      end

      S_PLAY: begin
        // Eating scores even in the cycle that finish or death exits.
        if (eat) score_d = score_sat;
        if (finish) begin
          frame_cnt_d = 8'd0;
          flash_cnt_d = 8'd0;
          flash_d     = 1'b1;
          state_d     = S_CLEAR;
        end else if (pac_dead) begin
          lives_d     = lives_q - 2'd1;
          frame_cnt_d = 8'd0;
          state_d     = S_DYING;
        end
      end

      S_DYING: begin
        if (frame_tick) begin
          if (frame_cnt_q == DEATH_LAST) begin
            frame_cnt_d = 8'd0;
            // No reload after a death: remaining pellets are kept.
            state_d     = (lives_q == 2'd0) ? S_GAMEOVER : S_READY;
          end else begin
            frame_cnt_d = frame_cnt_q + 8'd1;
          end
        end
      end

      S_CLEAR: begin
        if (frame_tick) begin
          if (frame_cnt_q == CLEAR_LAST) begin
            frame_cnt_d = 8'd0;
            flash_d     = 1'b0;
            level_d     = (level_q >= LEVEL_MAX) ? LEVEL_MAX : level_q + 4'd1;
            state_d     = S_RELOAD;
          end else begin
            frame_cnt_d = frame_cnt_q + 8'd1;
            if (flash_cnt_q == FLASH_LAST) begin
              flash_cnt_d = 8'd0;
              flash_d     = ~flash_q;
            end else begin
              flash_cnt_d = flash_cnt_q + 8'd1;
            end
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (Reset) begin
      state_q      <= S_IDLE;
      frame_cnt_q  <= 8'd0;
      flash_cnt_q  <= 8'd0;
      flash_q      <= 1'b0;
      score_q      <= 16'd0;
      lives_q      <= LIVES_INIT;
      level_q      <= 4'd1;
      map_reload_q <= 1'b0;
      play_en_q    <= 1'b0;
      start_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_cnt_q  <= frame_cnt_d;
      flash_cnt_q  <= flash_cnt_d;
      flash_q      <= flash_d;
      score_q      <= score_d;
      lives_q      <= lives_d;
      level_q      <= level_d;
      // RELOAD always lasts exactly one cycle, so this is a single pulse.
      map_reload_q <= (state_d == S_RELOAD);
      play_en_q    <= (state_d == S_PLAY);
      start_q      <= start;
    end
  end

  assign map_reload = map_reload_q;
  assign play_en    = play_en_q;
  assign flash      = flash_q;
  assign score      = score_q;
  assign lives      = lives_q;
  assign level      = level_q;
  assign state      = state_q;

endmodule
